// File: rtl/scan_decrypt_ctrl_if.sv
// -----------------------------------------------------------------------------
// scan_decrypt_ctrl_if
//   Start/done handshake between the scan receive controller and an external
//   AES-128 decrypt core.
//
//   dec_ct     ciphertext to the core, stable from dec_start until dec_done
//   dec_start  single-cycle request pulse to the core
//   dec_pt     plaintext from the core, valid while dec_done is high
//   dec_done   core completion strobe
//
//   master : controller side (drives dec_ct/dec_start)
//   slave  : decrypt core side (drives dec_pt/dec_done)
// -----------------------------------------------------------------------------
interface scan_decrypt_ctrl_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] dec_ct;
  logic              dec_start;
  logic [DATA_W-1:0] dec_pt;
  logic              dec_done;

  modport master (output dec_ct, dec_start, input dec_pt, dec_done);
  modport slave  (input dec_ct, dec_start, output dec_pt, dec_done);
endinterface

// File: rtl/scan_decrypt_ctrl.sv
// -----------------------------------------------------------------------------
// scan_decrypt_ctrl
//   Receive-side scan controller for the encrypted test path. Deserializes a
//   DATA_W-bit ciphertext frame from serial_in (MSB first), hands it to the
//   decrypt core, then serializes the plaintext on serial_out (MSB first)
//   while the next ciphertext frame shifts in at the same time.
//
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   shift_en    one scan bit moves per cycle while high
//   serial_in   ciphertext scan bit
//   dec         decrypt core handshake (master side)
//   serial_out  plaintext scan bit, out_reg MSB
//   out_valid   high while serial_out carries plaintext
//   frame_done  one-cycle pulse after the last plaintext bit of a frame
//   overrun     sticky: shift_en seen while the frame was with the core
//   dec_err     sticky: decrypt core timed out
// -----------------------------------------------------------------------------
module scan_decrypt_ctrl #(
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                serial_in,
  scan_decrypt_ctrl_if.master dec,
  output logic                serial_out,
  output logic                out_valid,
  output logic                frame_done,
  output logic                overrun,
  output logic                dec_err
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_FILL,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   in_reg, out_reg, dec_ct;
  logic [DATA_W-1:0]   in_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt, wait_inc;
  logic                shift_last;
  logic                wait_expired;

  assign in_next    = {in_reg[DATA_W-2:0], serial_in};
  assign shift_last = shift_en && (bit_cnt == CNT_W'(DATA_W - 1));
  // The abort fires on the cycle whose increment would bring wait_cnt to
  // TIMEOUT-1, so dec_err lands exactly TIMEOUT cycles after dec_start.
  assign wait_inc     = wait_cnt + WAIT_W'(1);
  assign wait_expired = (wait_inc == WAIT_W'(TIMEOUT - 1));

  assign serial_out = out_reg[DATA_W-1];
  assign dec.dec_ct = dec_ct;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    dec.dec_start = 1'b0;
    out_valid     = 1'b0;
    case (state)
      S_FILL:  if (shift_last) state_next = S_START;
      S_START: begin
        dec.dec_start = 1'b1;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a coincident timeout
        if (dec.dec_done)      state_next = S_DRAIN;
        else if (wait_expired) state_next = S_FILL;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (shift_last) state_next = S_START;
      end
      default: state_next = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FILL;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg     <= '0;
      out_reg    <= '0;
      dec_ct     <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      dec_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_FILL: begin
          if (shift_en) begin
            in_reg <= in_next;
            if (shift_last) begin
              dec_ct  <= in_next;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_START: begin
          wait_cnt <= '0;
          // the frame is with the core; a scan bit now has nowhere to go
          if (shift_en) overrun <= 1'b1;
        end
        S_WAIT: begin
          if (shift_en) overrun <= 1'b1;
          if (dec.dec_done) begin
            out_reg <= dec.dec_pt;
          end else if (wait_expired) begin
            dec_err <= 1'b1;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_DRAIN: begin
          if (shift_en) begin
            // full duplex: plaintext out, next ciphertext in
            in_reg  <= in_next;
            out_reg <= {out_reg[DATA_W-2:0], 1'b0};
            if (shift_last) begin
              frame_done <= 1'b1;
              dec_ct     <= in_next;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
